axis_fifo_s_v2_0: RTL
=====================

Name: axis_fifo_s_v2_0

Overview:
- Single-clock AXI4-Stream slave FIFO with a parametrised width downsizer on the read side.
- Accepts C_S_AXIS_TDATA_WIDTH beats and stores them with tkeep/tlast.
- Presents READ_DATA_WIDTH words to a first-word-fall-through pop interface, skipping empty byte lanes and marking packet ends.
- Optional packet mode holds data back until a whole packet is stored. Sits between a DMA/stream source and register- or logic-side consumers in the same clock domain.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, input beat width; multiple of READ_DATA_WIDTH.
- READ_DATA_WIDTH, 8, output word width; multiple of 8. RATIO = C_S_AXIS_TDATA_WIDTH/READ_DATA_WIDTH (1..16).
- FIFO_DEPTH, 16, storage depth in input beats; power of 2, ≥4.
- PACKET_MODE, 0, 1 = output gated until a tlast beat is stored.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tready  out  1  slave ready.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  beat data.
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  beat valid.
- rd_en  in  1  pop current output word.
- dout  out  READ_DATA_WIDTH  current output word (FWFT).
- dout_last  out  1  dout is last word of a packet.
- empty  out  1  no readable word.
- data_count  out  log2(FIFO_DEPTH)+1  beats stored, including the beat being unpacked.
- pkt_count  out  log2(FIFO_DEPTH)+1  complete packets (tlast beats) stored.

Behaviour:
- Reset is asynchronous. While s_axis_aresetn=0: tready=0, empty=1, dout=0, dout_last=0, data_count=0, pkt_count=0, pointers and lane index = 0. After release, tready=1 on the first clock edge.
- Write occurs when tvalid&tready. Stored fields: tdata, tlast, lane mask. Lane i covers tdata[READ_DATA_WIDTH*(i+1)-1 : READ_DATA_WIDTH*i]. Lane i is valid if any tkeep bit of that lane is 1. An all-zero tkeep beat is stored with only lane 0 valid.
- tready = registered (data_count_next < FIFO_DEPTH). A pop in the same cycle as a full condition does not allow a same-cycle write; tready rises the cycle after the beat is freed.
- data_count: +1 on write, −1 when the last valid lane of the head beat is popped; simultaneous write and pop leaves it unchanged.
- Output lanes are emitted lowest-first; invalid lanes are skipped with no bubble. dout_last=1 only on the highest valid lane of a tlast beat.
- Latency, non-packet mode: a beat written at edge N gives empty=0 and its first valid lane on dout after edge N+1.
- Pop: rd_en=1 and empty=0 advances to the next valid lane or the next beat at that edge. rd_en while empty=1 is ignored with no state change.
- Back-to-back pops give one word per cycle across beat boundaries with no gap.
- Packet mode (PACKET_MODE=1):
  - empty = (no beats) OR (pkt_count=0 AND data_count<FIFO_DEPTH).
  - pkt_count: +1 on a tlast write, −1 on popping the dout_last word.
  - Deadlock release: when the FIFO is full with pkt_count=0, data becomes readable.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from data_count, not from pointer compare.
- Reset mid-packet discards all content and partial unpack state; the first beat after reset starts at lane 0.
- RATIO=1: a pure FIFO; dout_last = stored tlast.

Test Plan:
- Defaults: write 0x44332211, tkeep=0xF, tlast=1; pop 4 times → dout 0x11,0x22,0x33,0x44; dout_last=1 only on 0x44; empty=1 after the 4th pop.
- Write 0xAABBCCDD, tkeep=0x3, tlast=1 → dout 0xDD then 0xCC with dout_last=1; 0xBB/0xAA are never emitted. A tkeep=0xA beat yields 0xCC, 0xAA.
- Full: 17 consecutive beats with no pops → 16 accepted; tready=0 from the cycle after the 16th write; data_count=16. One full-beat pop (4 words) → tready=1 on the next cycle and the 17th beat is accepted.
- PACKET_MODE=1: 3 beats with tlast=0 → empty stays 1. A 4th beat with tlast=1 → empty=0 next cycle, pkt_count=1; 16 pops drain it, with dout_last on the 16th.
- PACKET_MODE=1, DEPTH 16: 16 beats without tlast → empty falls once data_count=16 (deadlock release).
- Assert reset after 2 words of a beat are popped → all outputs at reset values. A post-reset write of 0x04030201 → dout 0x01 first.

Source files
------------

// File: rtl/axis_fifo_s_v2_0.sv
// AXI4-Stream slave FIFO with a read-side width downsizer and first-word-fall-through pop port.
// Empty byte lanes are skipped. Optional packet mode holds output until a full packet is stored.
`timescale 1ns/1ps

module axis_fifo_s_v2_0 #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int READ_DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH           = 16,
    parameter int PACKET_MODE          = 0
) (
    input  logic                              s_axis_aclk,
    input  logic                              s_axis_aresetn,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    input  logic                              rd_en,
    output logic [READ_DATA_WIDTH-1:0]        dout,
    output logic                              dout_last,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH):0]       data_count,
    output logic [$clog2(FIFO_DEPTH):0]       pkt_count
);

    localparam int RATIO = C_S_AXIS_TDATA_WIDTH / READ_DATA_WIDTH;
    localparam int BPL   = READ_DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [LW-1:0] LANE_ONE = 1;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [RATIO-1:0]                mem_mask [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]           mem_last;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] lane_idx;
    logic          wr_q;

    logic [RATIO-1:0]                wr_mask;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] head_data;
    logic [RATIO-1:0]                head_mask;
    logic                            head_last;
    logic [LW-1:0]                   cur_lane;
    logic                            lane_found;
    logic                            has_next;
    logic [READ_DATA_WIDTH-1:0]      lane_word;

    logic          wr_fire;
    logic          pop;
    logic          beat_pop;
    logic          no_beats;
    logic          empty_w;
    logic [AW:0]   dc_next;
    logic [AW:0]   pc_next;

    // A lane is kept if any of its bytes is kept; an all-empty beat still yields lane 0.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < RATIO; i++) begin
            wr_mask[i] = |s_axis_tkeep[i*BPL +: BPL];
        end
        if (s_axis_tkeep == '0) begin
            wr_mask[0] = 1'b1;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (wr_fire) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_mask[wr_ptr] <= wr_mask;
            mem_last[wr_ptr] <= s_axis_tlast;
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_mask = mem_mask[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    // Current lane is the lowest kept lane at or above lane_idx.
    always_comb begin
        cur_lane   = '0;
        lane_found = 1'b0;
        has_next   = 1'b0;
        lane_word  = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (!lane_found && head_mask[i] && (i >= int'(lane_idx))) begin
                cur_lane   = LW'(i);
                lane_found = 1'b1;
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (head_mask[i] && (i > int'(cur_lane))) begin
                has_next = 1'b1;
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (LW'(i) == cur_lane) begin
                lane_word = head_data[i*READ_DATA_WIDTH +: READ_DATA_WIDTH];
            end
        end
    end

    // The most recently written beat becomes visible one cycle after its write.
    assign no_beats = (data_count == {{AW{1'b0}}, wr_q});
    assign empty_w  = (PACKET_MODE != 0)
                    ? (no_beats || ((pkt_count == '0) && (data_count < FULL_CNT)))
                    : no_beats;

    assign wr_fire  = s_axis_tvalid & s_axis_tready;
    assign pop      = rd_en & ~empty_w;
    assign beat_pop = pop & ~has_next;

    assign empty     = empty_w;
    assign dout      = empty_w ? '0 : lane_word;
    assign dout_last = ~empty_w & head_last & ~has_next;

    always_comb begin
        dc_next = data_count;
        case ({wr_fire, beat_pop})
            2'b10:   dc_next = data_count + CNT_ONE;
            2'b01:   dc_next = data_count - CNT_ONE;
            default: dc_next = data_count;
        endcase
    end

    always_comb begin
        pc_next = pkt_count;
        case ({wr_fire & s_axis_tlast, pop & dout_last})
            2'b10:   pc_next = pkt_count + CNT_ONE;
            2'b01:   pc_next = pkt_count - CNT_ONE;
            default: pc_next = pkt_count;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            lane_idx      <= '0;
            wr_q          <= 1'b0;
            data_count    <= '0;
            pkt_count     <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            wr_q          <= wr_fire;
            data_count    <= dc_next;
            pkt_count     <= pc_next;
            s_axis_tready <= (dc_next < FULL_CNT);
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (beat_pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                lane_idx <= '0;
            end else if (pop) begin
                lane_idx <= cur_lane + LANE_ONE;
            end
        end
    end

endmodule
